// File: rtl/sram_read_arbiter_pkg.sv
// sram_read_arbiter_pkg: shared SRAM widths, owner encoding and arbiter types.
package sram_read_arbiter_pkg;
    localparam int SRAM_WORD_WIDTH = 16;
    localparam int SRAM_ADDR_BIT = 10;
    localparam logic OWNER_T = 1'b0;
    localparam logic OWNER_Q = 1'b1;
    typedef logic [SRAM_ADDR_BIT-1:0] sram_addr_t;
    typedef logic [SRAM_WORD_WIDTH-1:0] sram_word_t;
    typedef enum logic {PRI_T, PRI_Q} arb_state_e;
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;
endpackage

// File: rtl/sram_read_arbiter_if.sv
// sram_read_arbiter_if: requester, flush and SRAM port signals of the read arbiter.
interface sram_read_arbiter_if;
    import sram_read_arbiter_pkg::*;
    logic t_request_i, q_request_i, flush_i;
    sram_addr_t t_addr_i, q_addr_i, sram_addr_o;
    sram_word_t t_data_o, q_data_o, sram_data_i;
    logic t_valid_o, q_valid_o, sram_cen_o, busy_o;
    modport master (
        output t_request_i, t_addr_i, q_request_i, q_addr_i, flush_i, sram_data_i,
        input t_data_o, t_valid_o, q_data_o, q_valid_o, sram_cen_o, sram_addr_o, busy_o
    );
    modport slave (
        input t_request_i, t_addr_i, q_request_i, q_addr_i, flush_i, sram_data_i,
        output t_data_o, t_valid_o, q_data_o, q_valid_o, sram_cen_o, sram_addr_o, busy_o
    );
endinterface

// File: rtl/sram_tag_pipe.sv
// sram_tag_pipe: DEPTH-stage {valid, owner} shift register with synchronous clear.
module sram_tag_pipe
    import sram_read_arbiter_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic busy_next
);
    tag_t stage [DEPTH];

    always_ff @(posedge clk) stage[0] <= (rst || clr) ? '0 : tag_in;

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        always_ff @(posedge clk) stage[i] <= (rst || clr) ? '0 : stage[i-1];
    end

    assign tag_out = stage[DEPTH-1];

    // Occupancy after the coming edge: the last stage shifts out, a new tag may shift in.
    always_comb begin
        busy_next = tag_in.valid;
        for (int i = 0; i < DEPTH-1; i++) busy_next = busy_next | stage[i].valid;
        busy_next = busy_next & ~clr;
    end
endmodule

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: two-requester round-robin arbiter for a fixed-latency SRAM read port.
module sram_read_arbiter
    import sram_read_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rst,
    sram_read_arbiter_if.slave bus
);
    arb_state_e state, state_n;
    logic pend_t, pend_q, pend_t_n, pend_q_n;
    logic elig_t, elig_q, grant_t, grant_q;
    logic ret_t, ret_q, tags_busy_n;
    tag_t tag_in, tag_out;

    assign elig_t = bus.t_request_i && !pend_t && !bus.flush_i;
    assign elig_q = bus.q_request_i && !pend_q && !bus.flush_i;

    always_ff @(posedge clk) state <= rst ? PRI_T : state_n;

    always_comb state_n = grant_t ? PRI_Q : grant_q ? PRI_T : state;

    always_comb begin
        grant_t = elig_t && (!elig_q || state == PRI_T);
        grant_q = elig_q && (!elig_t || state == PRI_Q);
    end

    assign tag_in.valid = grant_t || grant_q;
    assign tag_in.owner = grant_q ? OWNER_Q : OWNER_T;

    sram_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk(clk),
        .rst(rst),
        .clr(bus.flush_i),
        .tag_in(tag_in),
        .tag_out(tag_out),
        .busy_next(tags_busy_n)
    );

    // A tag leaving the pipe during a flush belongs to a discarded read.
    assign ret_t = tag_out.valid && tag_out.owner == OWNER_T && !bus.flush_i;
    assign ret_q = tag_out.valid && tag_out.owner == OWNER_Q && !bus.flush_i;

    assign pend_t_n = !bus.flush_i && (grant_t || (pend_t && !bus.t_valid_o));
    assign pend_q_n = !bus.flush_i && (grant_q || (pend_q && !bus.q_valid_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_t <= 1'b0;
            pend_q <= 1'b0;
            bus.sram_cen_o <= 1'b0;
            bus.sram_addr_o <= '0;
            bus.t_valid_o <= 1'b0;
            bus.q_valid_o <= 1'b0;
            bus.t_data_o <= '0;
            bus.q_data_o <= '0;
            bus.busy_o <= 1'b0;
        end else begin
            pend_t <= pend_t_n;
            pend_q <= pend_q_n;
            bus.sram_cen_o <= grant_t || grant_q;
            if (grant_t || grant_q) bus.sram_addr_o <= grant_t ? bus.t_addr_i : bus.q_addr_i;
            bus.t_valid_o <= ret_t;
            bus.q_valid_o <= ret_q;
            if (ret_t) bus.t_data_o <= bus.sram_data_i;
            if (ret_q) bus.q_data_o <= bus.sram_data_i;
            bus.busy_o <= pend_t_n || pend_q_n || tags_busy_n;
        end
    end
endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb_sram_read_arbiter: directed and random stimulus against a transaction-level read model.
module tb_sram_read_arbiter;
    import sram_read_arbiter_pkg::*;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int rc = 0;

    sram_read_arbiter_if bus();

    sram_read_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic sram_word_t mem_word(input sram_addr_t a);
        return sram_word_t'(a) * 16'd257 + 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: data for a read enabled in cycle k appears in cycle k+RD_LAT, junk otherwise.
    logic hist_cen [RD_LAT+1];
    sram_addr_t hist_addr [RD_LAT+1];
    initial begin
        for (int i = 0; i <= RD_LAT; i++) begin
            hist_cen[i] = 1'b0;
            hist_addr[i] = '0;
        end
        bus.sram_data_i = '0;
    end
    always @(negedge clk) begin
        for (int i = RD_LAT; i > 0; i--) begin
            hist_cen[i] = hist_cen[i-1];
            hist_addr[i] = hist_addr[i-1];
        end
        hist_cen[0] = bus.sram_cen_o;
        hist_addr[0] = bus.sram_addr_o;
        bus.sram_data_i = hist_cen[RD_LAT] ? mem_word(hist_addr[RD_LAT]) : sram_word_t'($urandom);
    end

    // Reference: each requester owns at most one read, known by its return cycle and address.
    bit have_exp = 0;
    bit pri_q = 0;
    bit ta = 0, qa = 0;
    int td = 0, qd = 0, n = 0;
    sram_addr_t tadr, qadr, e_addr;
    sram_word_t e_tdata, e_qdata;
    bit e_cen, e_tv, e_qv, e_busy;
    always @(negedge clk) begin
        bit el_t, el_q, g_t, g_q;
        n++;
        if (have_exp) begin
            chk("cen", 32'(bus.sram_cen_o), 32'(e_cen));
            chk("addr", 32'(bus.sram_addr_o), 32'(e_addr));
            chk("t_valid", 32'(bus.t_valid_o), 32'(e_tv));
            chk("q_valid", 32'(bus.q_valid_o), 32'(e_qv));
            chk("t_data", 32'(bus.t_data_o), 32'(e_tdata));
            chk("q_data", 32'(bus.q_data_o), 32'(e_qdata));
            chk("busy", 32'(bus.busy_o), 32'(e_busy));
        end
        if (rst) begin
            have_exp = 1;
            pri_q = 0;
            ta = 0;
            qa = 0;
            {e_cen, e_tv, e_qv, e_busy} = '0;
            e_addr = '0;
            e_tdata = '0;
            e_qdata = '0;
        end else if (have_exp) begin
            el_t = bus.t_request_i && !ta && !bus.flush_i;
            el_q = bus.q_request_i && !qa && !bus.flush_i;
            g_t = el_t && (!el_q || !pri_q);
            g_q = el_q && !g_t;
            if (g_t) pri_q = 1;
            else if (g_q) pri_q = 0;
            if (bus.flush_i) begin
                ta = 0;
                qa = 0;
            end
            if (ta && td == n) ta = 0;
            if (qa && qd == n) qa = 0;
            e_cen = g_t || g_q;
            if (g_t) e_addr = bus.t_addr_i;
            if (g_q) e_addr = bus.q_addr_i;
            if (g_t) begin
                ta = 1;
                td = n + 2 + RD_LAT;
                tadr = bus.t_addr_i;
            end
            if (g_q) begin
                qa = 1;
                qd = n + 2 + RD_LAT;
                qadr = bus.q_addr_i;
            end
            e_tv = ta && td == n + 1;
            e_qv = qa && qd == n + 1;
            if (e_tv) e_tdata = mem_word(tadr);
            if (e_qv) e_qdata = mem_word(qadr);
            e_busy = ta || qa;
        end
    end

    task automatic go(input int k);
        while (rc < k) begin
            @(posedge clk);
            #1;
            rc++;
        end
    endtask

    task automatic idle();
        bus.t_request_i = 1'b0;
        bus.q_request_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.t_addr_i = '0;
        bus.q_addr_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        rc = 0;
    endtask

    initial begin
        int nt, nq;
        idle();
        // T alone: grant 0, read data at 4, next grant at 5
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd5;
        @(negedge clk);
        chk("rst_cen", 32'(bus.sram_cen_o), 0);
        chk("rst_addr", 32'(bus.sram_addr_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_tvalid", 32'(bus.t_valid_o), 0);
        chk("rst_tdata", 32'(bus.t_data_o), 0);
        go(1); @(negedge clk);
        chk("solo_cen1", 32'(bus.sram_cen_o), 1);
        chk("solo_addr1", 32'(bus.sram_addr_o), 5);
        go(4); @(negedge clk);
        chk("solo_tvalid4", 32'(bus.t_valid_o), 1);
        chk("solo_tdata4", 32'(bus.t_data_o), 32'h1739);
        go(5); @(negedge clk);
        chk("solo_cen5", 32'(bus.sram_cen_o), 0);
        go(6); @(negedge clk);
        chk("solo_cen6", 32'(bus.sram_cen_o), 1);
        // both at once: T first, Q next cycle
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd3;
        bus.q_request_i = 1'b1;
        bus.q_addr_i = 10'd9;
        go(1); @(negedge clk);
        chk("both_addr1", 32'(bus.sram_addr_o), 3);
        go(2); @(negedge clk);
        chk("both_cen2", 32'(bus.sram_cen_o), 1);
        chk("both_addr2", 32'(bus.sram_addr_o), 9);
        go(4); @(negedge clk);
        chk("both_tvalid4", 32'(bus.t_valid_o), 1);
        chk("both_qvalid4", 32'(bus.q_valid_o), 0);
        chk("both_tdata4", 32'(bus.t_data_o), 32'h1537);
        go(5); @(negedge clk);
        chk("both_qvalid5", 32'(bus.q_valid_o), 1);
        chk("both_tvalid5", 32'(bus.t_valid_o), 0);
        chk("both_qdata5", 32'(bus.q_data_o), 32'h1B3D);
        // continuous contention over cycles 0..40: 8 returns each
        do_reset();
        nt = 0;
        nq = 0;
        bus.t_request_i = 1'b1;
        bus.q_request_i = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            go(k);
            bus.t_addr_i = sram_addr_t'($urandom);
            bus.q_addr_i = sram_addr_t'($urandom);
            @(negedge clk);
            nt += int'(bus.t_valid_o);
            nq += int'(bus.q_valid_o);
        end
        chk("contend_tcount", 32'(nt), 8);
        chk("contend_qcount", 32'(nq), 8);
        // flush at 2 with T still requesting: no return at 4, re-grant at 3
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd7;
        go(2);
        bus.flush_i = 1'b1;
        go(3);
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy3", 32'(bus.busy_o), 0);
        go(4); @(negedge clk);
        chk("flush_tvalid4", 32'(bus.t_valid_o), 0);
        chk("flush_regrant", 32'(bus.sram_cen_o), 1);
        // flush at 2 with T gone: idle by 4
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd7;
        go(1);
        bus.t_request_i = 1'b0;
        go(2);
        bus.flush_i = 1'b1;
        go(3);
        bus.flush_i = 1'b0;
        go(4); @(negedge clk);
        chk("flush2_tvalid4", 32'(bus.t_valid_o), 0);
        chk("flush2_busy4", 32'(bus.busy_o), 0);
        // reset at 2 with both reads in flight
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd3;
        bus.q_request_i = 1'b1;
        bus.q_addr_i = 10'd9;
        go(2);
        rst = 1'b1;
        go(3);
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("mrst_cen3", 32'(bus.sram_cen_o), 0);
        chk("mrst_addr3", 32'(bus.sram_addr_o), 0);
        chk("mrst_busy3", 32'(bus.busy_o), 0);
        for (int k = 4; k <= 8; k++) begin
            go(k); @(negedge clk);
            chk("mrst_tvalid", 32'(bus.t_valid_o), 0);
            chk("mrst_qvalid", 32'(bus.q_valid_o), 0);
        end
        // request dropped after grant: return still arrives
        do_reset();
        bus.t_request_i = 1'b1;
        bus.t_addr_i = 10'd5;
        go(1);
        bus.t_request_i = 1'b0;
        go(4); @(negedge clk);
        chk("drop_tvalid4", 32'(bus.t_valid_o), 1);
        chk("drop_busy4", 32'(bus.busy_o), 1);
        go(5); @(negedge clk);
        chk("drop_busy5", 32'(bus.busy_o), 0);
        // random traffic with occasional flushes and resets
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 249) == 0);
            bus.flush_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) bus.t_request_i = ~bus.t_request_i;
            if ($urandom_range(0, 3) == 0) bus.q_request_i = ~bus.q_request_i;
            bus.t_addr_i = sram_addr_t'($urandom);
            bus.q_addr_i = sram_addr_t'($urandom);
        end
        rst = 1'b0;
        idle();
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
